ram_16x8: RTL

Addressed memory at the far end of the memory-address register. It takes the 4-bit address the MAR drives and holds sixteen 8-bit words. In normal CPU operation it serves bus writes (RAM-in) and registered reads (RAM-out). A program-load mode streams a program image into consecutive addresses from 0 over a valid/ready handshake before the CPU runs, replacing the manual DIP-switch programming path.

---
 rtl/ram_16x8_if.sv | 36 +++
 rtl/ram_16x8.sv | 103 ++++++++++
 2 files changed

// File: rtl/ram_16x8_if.sv
// CPU bus and program-loader signals between the
// controller side (master) and ram_16x8 (slave).
interface ram_16x8_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d_in;
  logic              ri;
  logic              ro;
  logic [DATA_W-1:0] ram_out;
  logic              rd_valid;
  logic              prog;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              ld_done;
  logic              busy;

  modport master (
    output addr, d_in, ri, ro,
    output prog, ld_valid, ld_data,
    input  ram_out, rd_valid,
    input  ld_ready, ld_count,
    input  ld_done, busy
  );

  modport slave (
    input  addr, d_in, ri, ro,
    input  prog, ld_valid, ld_data,
    output ram_out, rd_valid,
    output ld_ready, ld_count,
    output ld_done, busy
  );
endinterface

// File: rtl/ram_16x8.sv
// 16x8 RAM behind the MAR with registered reads and a
// valid/ready program loader that fills words from 0.
module ram_16x8 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic      clk,
  input  logic      clr,
  ram_16x8_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              rdv_q, rdv_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rdv_d   = 1'b0;
    we      = 1'b0;
    waddr   = bus.addr;
    wdata   = bus.d_in;
    unique case (state_q)
      RUN: begin
        if (bus.ri) begin
          we = 1'b1;
        end else if (bus.ro) begin
          out_d = mem_q[bus.addr];
          rdv_d = 1'b1;
        end
        if (bus.prog) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // prog drop wins over a same-cycle accept
        if (!bus.prog) begin
          state_d = RUN;
        end else if (bus.ld_valid) begin
          we    = 1'b1;
          waddr = ptr_q;
          wdata = bus.ld_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        if (!bus.prog) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      rdv_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rdv_q   <= rdv_d;
      if (we) mem_q[waddr] <= wdata;
    end
  end

  assign bus.ram_out  = out_q;
  assign bus.rd_valid = rdv_q;
  assign bus.ld_count = cnt_q;
  assign bus.ld_ready = (state_q == LOAD);
  assign bus.ld_done  = (state_q == DONE);
  assign bus.busy     = (state_q != RUN);
endmodule
